// File: rtl/counter_snapshot_pkg.sv
// Shared types and constants for the counter snapshot FIFO.
// Optional feature macro: SNAPSHOT_DELTA_EN (adds out_delta on the top module).
package counter_snapshot_pkg;

  localparam int DATA_W_DEF = 36;
  localparam int TS_W_DEF   = 12;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_W_DEF = 8;

  // Saturation value of the drop counter at its default width.
  localparam logic [DROP_W_DEF-1:0] DROP_SAT = {DROP_W_DEF{1'b1}};

  // One captured sample: counter value plus timestamp.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] count;
    logic [TS_W_DEF-1:0]   ts;
  } entry_t;

  // Address width for a FIFO of the given depth (pointer width minus wrap bit).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/snapshot_fifo_mem.sv
// Register-array storage for the snapshot FIFO: synchronous write and a
// registered read at an address. A read of the address being written in the
// same cycle returns the new data, so the read register always reflects the
// array contents after the current edge.
// Optional feature macro: SNAPSHOT_DELTA_EN (not used in this file).
module snapshot_fifo_mem
  import counter_snapshot_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Next array contents: one entry replaced on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Next read data, forwarding a same-address write.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end else begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Storage array; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read data register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= {WIDTH{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/counter_snapshot_fifo.sv
// Counter snapshot FIFO: captures {count_in, ts_in} on each trig cycle into a
// first-word-fall-through FIFO drained over valid/ready, with sticky overflow
// and a saturating drop counter for captures lost while full.
// Optional feature macro: SNAPSHOT_DELTA_EN adds out_delta, the head count
// minus the most recently popped count (modulo 2^DATA_W).
module counter_snapshot_fifo
  import counter_snapshot_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF,
  parameter int AW     = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] count_in,
  input  logic [TS_W-1:0]   ts_in,
  input  logic              trig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_count,
  output logic [TS_W-1:0]   out_ts,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
`ifdef SNAPSHOT_DELTA_EN
  output logic [DATA_W-1:0] out_delta,
`endif
  input  logic              clr_ovf
);

  localparam int WIDTH = DATA_W + TS_W;
  localparam logic [AW:0]       PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DROP_TOP = {DROP_W{1'b1}};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              wr_en_s;
  logic [WIDTH-1:0]  wr_data_s;
  logic [WIDTH-1:0]  rd_data_s;

  // Full and empty come from the wrap-bit pointer comparison.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop needs a head entry; a push into a full FIFO only fits alongside a pop.
  assign pop_s     = out_valid && out_ready && !empty_s;
  assign push_s    = trig && (!full_s || pop_s);
  assign drop_s    = trig && full_s && !pop_s;
  assign wr_en_s   = push_s && reset;
  assign wr_data_s = {count_in, ts_in};

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
  end

  // Overflow flag and drop counter; a drop in the clear cycle still counts.
  always_comb begin
    overflow_d = drop_s || (overflow_q && !clr_ovf);
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      drop_cnt_d = drop_s ? DROP_ONE : {DROP_W{1'b0}};
    end else if (drop_s && (drop_cnt_q != DROP_TOP)) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
      level_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // The read address is the post-edge head, so the registered read shows the
  // new head one cycle after a push into an empty FIFO or after a pop.
  snapshot_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data_s),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (rd_data_s)
  );

  assign out_valid = (level_q != {(AW+1){1'b0}});
  assign out_count = rd_data_s[WIDTH-1:TS_W];
  assign out_ts    = rd_data_s[TS_W-1:0];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef SNAPSHOT_DELTA_EN
  logic [DATA_W-1:0] prev_count_q, prev_count_d;

  // Remember the count of each entry as it is popped.
  always_comb begin
    if (pop_s) begin
      prev_count_d = out_count;
    end else begin
      prev_count_d = prev_count_q;
    end
  end

  // Previous-count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_count_q <= {DATA_W{1'b0}};
    end else begin
      prev_count_q <= prev_count_d;
    end
  end

  // Modular subtraction gives the right positive delta across counter wrap.
  assign out_delta = out_count - prev_count_q;
`endif

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// Scoreboard bench for counter_snapshot_fifo. Accepted captures push their
// expected entry into a queue; a monitor pops and compares on each handshake.
// Optional feature macro: SNAPSHOT_DELTA_EN (enables out_delta checks).
module tb_counter_snapshot_fifo;
  import counter_snapshot_pkg::*;

  logic        clk;
  logic        reset;
  logic [35:0] count_in;
  logic [11:0] ts_in;
  logic        trig;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_count;
  logic [11:0] out_ts;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        clr_ovf;
`ifdef SNAPSHOT_DELTA_EN
  logic [35:0] out_delta;
`endif

  typedef struct {
    entry_t      e;
    logic        chk_d;
    logic [35:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_bad;

  counter_snapshot_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .ts_in     (ts_in),
    .trig      (trig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_ts    (out_ts),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
`ifdef SNAPSHOT_DELTA_EN
    .out_delta (out_delta),
`endif
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One trig cycle; an accepted capture queues its expected entry.
  task automatic cap(input logic [35:0] c, input logic [11:0] t, input bit acc,
                     input bit cd, input logic [35:0] d);
    exp_t x;
    trig     = 1'b1;
    count_in = c;
    ts_in    = t;
    if (acc) begin
      x.e.count = c;
      x.e.ts    = t;
      x.chk_d   = cd;
      x.d       = d;
      exp_q.push_back(x);
    end
    step();
    trig = 1'b0;
  endtask

  // Drain with a cycle budget; the monitor checks each popped entry.
  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && out_valid; k++) step();
    out_ready = 1'b0;
    chk({name, "_timeout_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_left_in_queue"}, exp_q.size(), 64'd0);
    chk({name, "_level"}, {60'd0, level}, 64'd0);
  endtask

  // Monitor: compare the head against the scoreboard on every handshake.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got count %0h, expected no entry", out_count);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_count", {28'd0, out_count}, {28'd0, mon_e.e.count});
        chk("pop_ts", {52'd0, out_ts}, {52'd0, mon_e.e.ts});
`ifdef SNAPSHOT_DELTA_EN
        if (mon_e.chk_d) chk("pop_delta", {28'd0, out_delta}, {28'd0, mon_e.d});
`endif
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    trig      = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    count_in  = 36'd0;
    ts_in     = 12'd0;

    // Reset then idle
    step();
    step();
    chk("rst_out_count", {28'd0, out_count}, 64'd0);
    chk("rst_out_ts", {52'd0, out_ts}, 64'd0);
    reset = 1'b1;
    step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_level", {60'd0, level}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);

    // Single capture, latency 1, stable under backpressure
    cap(36'h0_0000_00A5, 12'h123, 1'b1, 1'b0, 36'd0);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_count", {28'd0, out_count}, 64'hA5);
    chk("single_ts", {52'd0, out_ts}, 64'h123);
    chk("single_level", {60'd0, level}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_count", {28'd0, out_count}, 64'hA5);
      chk("hold_ts", {52'd0, out_ts}, 64'h123);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
    end
    drain("single_drain");

    // Fill and overflow: 10 trigs, last two dropped
    for (int i = 1; i <= 10; i++) begin
      cap(36'(i), 12'(12'h100 + i), (i <= 8), 1'b0, 36'd0);
    end
    chk("fill_level", {60'd0, level}, 64'd8);
    chk("fill_overflow", {63'd0, overflow}, 64'd1);
    chk("fill_drop_cnt", {56'd0, drop_cnt}, 64'd2);

    // Full with simultaneous push and pop: no drop
    out_ready = 1'b1;
    cap(36'h99, 12'h199, 1'b1, 1'b0, 36'd0);
    out_ready = 1'b0;
    chk("fullpp_level", {60'd0, level}, 64'd8);
    chk("fullpp_drop_cnt", {56'd0, drop_cnt}, 64'd2);

    // Clear with a concurrent drop, then a plain clear
    clr_ovf = 1'b1;
    cap(36'hDEAD, 12'hEAD, 1'b0, 1'b0, 36'd0);
    chk("clrdrop_overflow", {63'd0, overflow}, 64'd1);
    chk("clrdrop_drop_cnt", {56'd0, drop_cnt}, 64'd1);
    step();
    clr_ovf = 1'b0;
    chk("clr_overflow", {63'd0, overflow}, 64'd0);
    chk("clr_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    chk("clr_level", {60'd0, level}, 64'd8);
    drain("fill_drain");

    // Empty with out_ready and trig: push only
    out_ready = 1'b1;
    cap(36'h55, 12'h055, 1'b1, 1'b0, 36'd0);
    chk("empty_rdy_level", {60'd0, level}, 64'd1);
    chk("empty_rdy_count", {28'd0, out_count}, 64'h55);
    step();
    out_ready = 1'b0;
    chk("empty_rdy_pop_level", {60'd0, level}, 64'd0);

    // Drop counter saturation
    for (int i = 0; i < 8; i++) cap(36'(36'h200 + i), 12'(i), 1'b1, 1'b0, 36'd0);
    for (int i = 0; i < 260; i++) cap(36'hBAD, 12'hBAD, 1'b0, 1'b0, 36'd0);
    chk("sat_drop_cnt", {56'd0, drop_cnt}, 64'hFF);
    chk("sat_overflow", {63'd0, overflow}, 64'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("sat_clr_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    drain("sat_drain");

    // Mid-operation reset discards entries; trig ignored in reset cycle
    for (int i = 0; i < 3; i++) cap(36'(36'h300 + i), 12'(i), 1'b1, 1'b0, 36'd0);
    chk("pre_rst_level", {60'd0, level}, 64'd3);
    reset    = 1'b0;
    trig     = 1'b1;
    count_in = 36'h777;
    step();
    trig = 1'b0;
    exp_q.delete();
    chk("midrst_level", {60'd0, level}, 64'd0);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_count", {28'd0, out_count}, 64'd0);
    reset = 1'b1;
    step();
    chk("postrst_level", {60'd0, level}, 64'd0);
    chk("postrst_valid", {63'd0, out_valid}, 64'd0);

    // Delta across counter wrap (previous count is 0 after reset)
    cap(36'hF_FFFF_FFFE, 12'h0A1, 1'b1, 1'b1, 36'hF_FFFF_FFFE);
    cap(36'h0_0000_0003, 12'h0A2, 1'b1, 1'b1, 36'h0_0000_0005);
    chk("delta_level", {60'd0, level}, 64'd2);
    drain("delta_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
